// File: rtl/nyx_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and instruction size helpers.
package nyx_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    function automatic int unsigned instr_bytes(input int unsigned width);
        return width / 8;
    endfunction

    localparam int unsigned INSTR_BYTES = instr_bytes(32);

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding read, result held until rdy_i; val_o two cycles after grant at best.
// Backpressure: HOLD keeps d_o/pc_o stable and issues no request until rdy_i or a redirect.
module fetch_stage
    import nyx_fetch_pkg::*;
#(
    parameter int unsigned                WIDTH      = 32,
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic                  rdy_i,
    output logic                  val_o,
    output logic [WIDTH-1:0]      d_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(instr_bytes(WIDTH));

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]      d_q, d_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                  mem_req, val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            d_q      <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            d_q      <= d_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        d_d      = d_q;
        pc_out_d = pc_out_q;
        mem_req  = 1'b0;
        val      = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                mem_req = 1'b1;
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = mem_gnt_i ? DROP : REQ;
                end else if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = mem_rvalid_i ? REQ : DROP;
                end else if (mem_rvalid_i) begin
                    d_d      = mem_rdata_i;
                    pc_out_d = pc_q;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                val = !redirect_i;
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = REQ;
                end else if (rdy_i) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = REQ;
                end
            end
            DROP: begin
                // A redirect alongside the stale response still retires it; staying would wait forever.
                if (redirect_i) pc_d = redirect_pc_i;
                if (mem_rvalid_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_o  = mem_req & reset;
    assign val_o      = val & reset;
    assign mem_addr_o = pc_q;
    assign d_o        = d_q;
    assign pc_o       = pc_out_q;

    rvalid_only_when_outstanding: assert property (
        @(posedge clk) disable iff (!reset)
        mem_rvalid_i |-> (state_q == WAIT || state_q == DROP)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rdy_i;
    logic        val_o;
    logic [31:0] d_o;
    logic [31:0] pc_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .WIDTH      (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .rdy_i         (rdy_i),
        .val_o         (val_o),
        .d_o           (d_o),
        .pc_o          (pc_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, drop all single-cycle controls, then let the outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
        redirect_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        rdy_i        = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        rdy_i         = 1'b0;

        step(); step();
        settle();
        check("rst_req",  mem_req_o, 0);
        check("rst_val",  val_o, 0);
        check("rst_d",    d_o, 0);
        check("rst_pc",   pc_o, 0);

        // First fetch: grant immediately, data one cycle later
        reset = 1'b1; settle();
        check("idle_req", mem_req_o, 0);
        check("idle_val", val_o, 0);
        step();
        mem_gnt_i = 1'b1; settle();
        check("req0_vld",  mem_req_o, 1);
        check("req0_addr", mem_addr_o, 32'h100);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; settle();
        check("wait0_req", mem_req_o, 0);
        check("wait0_val", val_o, 0);
        step();
        settle();
        check("hold0_val", val_o, 1);
        check("hold0_d",   d_o, 32'hDEAD_BEEF);
        check("hold0_pc",  pc_o, 32'h100);

        // Backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            check("bp_val", val_o, 1);
            check("bp_d",   d_o, 32'hDEAD_BEEF);
            check("bp_pc",  pc_o, 32'h100);
            check("bp_req", mem_req_o, 0);
            step(); settle();
        end
        rdy_i = 1'b1; settle();
        check("bp_xfer_val", val_o, 1);
        step();
        mem_gnt_i = 1'b1; settle();
        check("seq_req",  mem_req_o, 1);
        check("seq_addr", mem_addr_o, 32'h104);

        // Redirect in WAIT coinciding with the response
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h2000;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111; settle();
        check("rw_val", val_o, 0);
        step(); settle();
        check("rw_next_req",  mem_req_o, 1);
        check("rw_next_addr", mem_addr_o, 32'h2000);
        check("rw_drop_d",    d_o, 32'hDEAD_BEEF);
        check("rw_no_val",    val_o, 0);

        mem_gnt_i = 1'b1; settle();
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D; settle();
        step(); settle();
        check("h2_val", val_o, 1);
        check("h2_d",   d_o, 32'hCAFE_F00D);
        check("h2_pc",  pc_o, 32'h2000);

        // Redirect in HOLD beats rdy_i
        redirect_i = 1'b1; redirect_pc_i = 32'h3000; rdy_i = 1'b1; settle();
        check("rh_val", val_o, 0);
        step(); settle();
        check("rh_req",  mem_req_o, 1);
        check("rh_addr", mem_addr_o, 32'h3000);

        // Redirect with grant in REQ -> DROP, stale response discarded
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; mem_gnt_i = 1'b1; settle();
        step(); settle();
        check("drop_req", mem_req_o, 0);
        check("drop_val", val_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2222_2222; settle();
        step(); settle();
        check("drop_next_addr", mem_addr_o, 32'hFFFF_FFFC);
        check("drop_keep_d",    d_o, 32'hCAFE_F00D);

        // Wrap-around at top of address space
        mem_gnt_i = 1'b1; settle();
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_3333; settle();
        step(); settle();
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        rdy_i = 1'b1; settle();
        step(); settle();
        check("wrap_req",  mem_req_o, 1);
        check("wrap_addr", mem_addr_o, 32'h0);

        // Redirect in REQ without grant: old address now, new one next cycle
        redirect_i = 1'b1; redirect_pc_i = 32'h600; settle();
        check("rr_addr_now", mem_addr_o, 32'h0);
        step(); settle();
        check("rr_addr_next", mem_addr_o, 32'h600);
        check("rr_req_next",  mem_req_o, 1);

        // Reset asserted in WAIT
        mem_gnt_i = 1'b1; settle();
        step();
        reset = 1'b0; settle();
        check("rstw_val", val_o, 0);
        check("rstw_req", mem_req_o, 0);
        step();
        reset = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'h5000; settle();
        check("rstw_idle_req", mem_req_o, 0);
        check("rstw_idle_val", val_o, 0);
        check("rstw_idle_d",   d_o, 0);
        step(); settle();
        check("rstw_req_vld",  mem_req_o, 1);
        check("rstw_req_addr", mem_addr_o, 32'h100);
        check("rstw_req_val",  val_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
